// File: rtl/cpu_pkg.sv
// Shared widths and types for the decode/issue slice of the 16-bit core.
package cpu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_CTRL_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [DEF_CTRL_WIDTH-1:0] ctrl_t;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Priority bypass select for one source operand: r0, EX, MEM, WB, then regfile.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] operand
);

  // A load in EX has no result yet, so it never bypasses; the hazard logic stalls instead.
  always_comb begin
    operand = rf_data;
    if (rs == ADDR_WIDTH'(ZERO_REG)) begin
      operand = '0;
    end else if (ex_reg_write && !ex_is_load && ex_rd == rs) begin
      operand = ex_result;
    end else if (mem_reg_write && mem_rd == rs) begin
      operand = mem_result;
    end else if (wb_write_enable && wb_address == rs) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, bypass resolution, load-use stall and ID/EX register.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [ADDR_WIDTH-1:0] rf_read_address1,
  output logic [ADDR_WIDTH-1:0] rf_read_address2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op_a,
  output logic [DATA_WIDTH-1:0] out_op_b,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  hazard;
  logic                  accept;

  assign rf_read_address1 = in_rs1;
  assign rf_read_address2 = in_rs2;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs              (in_rs1),
    .rf_data         (rf_read_data1),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .ex_result       (ex_result),
    .mem_reg_write   (mem_reg_write),
    .mem_rd          (mem_rd),
    .mem_result      (mem_result),
    .wb_write_enable (wb_write_enable),
    .wb_address      (wb_address),
    .wb_data         (wb_data),
    .operand         (op_a)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs              (in_rs2),
    .rf_data         (rf_read_data2),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .ex_result       (ex_result),
    .mem_reg_write   (mem_reg_write),
    .mem_rd          (mem_rd),
    .mem_result      (mem_result),
    .wb_write_enable (wb_write_enable),
    .wb_address      (wb_address),
    .wb_data         (wb_data),
    .operand         (op_b)
  );

  // Load-use: a consumer of the loaded register must wait one cycle for MEM bypass.
  always_comb begin
    hazard = in_valid && ex_reg_write && ex_is_load && (ex_rd != ADDR_WIDTH'(ZERO_REG)) &&
             ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
    in_ready = !flush && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // ID/EX register; operands are captured only on accept and never re-resolved.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
      out_ctrl  <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op_a  <= op_a;
      out_op_b  <= op_b;
      out_imm   <= in_imm;
      out_rd    <= in_rd;
      out_ctrl  <= in_ctrl;
      out_pc    <= in_pc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && !flush && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, directed multi-cycle sequences, random run vs a model.
module tb_operand_fetch;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, in_ready4;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2;
  logic [15:0] in_imm, in_pc;
  logic [7:0]  in_ctrl;
  logic [4:0]  rf_read_address1, rf_read_address2, rf_ra4_1, rf_ra4_2;
  logic [15:0] rf_read_data1, rf_read_data2;
  logic        ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd;
  logic [15:0] ex_result;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [15:0] mem_result;
  logic        wb_write_enable;
  logic [4:0]  wb_address;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready, out_valid4;
  logic [15:0] out_op_a, out_op_b, out_imm, out_pc;
  logic [15:0] out_op_a4, out_op_b4, out_imm4, out_pc4;
  logic [4:0]  out_rd, out_rd4;
  logic [7:0]  out_ctrl, out_ctrl4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  logic [15:0] regs [32];
  int passed = 0;
  int total  = 0;
  int exp_stall;

  assign rf_read_data1 = (rf_read_address1 == 5'd0) ? 16'h0 : regs[rf_read_address1];
  assign rf_read_data2 = (rf_read_address2 == 5'd0) ? 16'h0 : regs[rf_read_address2];

  operand_fetch dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .rf_read_address1(rf_read_address1), .rf_read_address2(rf_read_address2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_write_enable(wb_write_enable), .wb_address(wb_address), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .stall_count(stall_count)
  );

  operand_fetch #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .rf_read_address1(rf_ra4_1), .rf_read_address2(rf_ra4_2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_write_enable(wb_write_enable), .wb_address(wb_address), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .out_op_a(out_op_a4), .out_op_b(out_op_b4), .out_imm(out_imm4), .out_rd(out_rd4),
    .out_ctrl(out_ctrl4), .out_pc(out_pc4), .stall_count(stall_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use2;
    logic        ex_we, ex_ld;
    logic [4:0]  ex_rd;
    logic [15:0] ex_res;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [15:0] mem_res;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [15:0] wb_dat;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock; the emulated regfile commits the WB write just after the edge.
  task automatic step();
    logic       we;
    logic [4:0] a;
    logic [15:0] d;
    we = wb_write_enable; a = wb_address; d = wb_data;
    @(posedge clock);
    #1;
    if (we && a != 5'd0) regs[a] = d;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 1; in_use_rs2 = 1;
    in_rd = 0; in_imm = 0; in_ctrl = 0; in_pc = 0;
    ex_reg_write = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_write_enable = 0; wb_address = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  // Reference operand value from the bypass rules, reading the emulated regfile.
  function automatic logic [15:0] resolve(input logic [4:0] rs);
    if (rs == 0) return 16'h0;
    if (ex_reg_write && !ex_is_load && ex_rd == rs) return ex_result;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_write_enable && wb_address == rs) return wb_data;
    return regs[rs];
  endfunction

  initial begin
    logic        m_valid, h, rdy;
    logic [15:0] m_a, m_b, m_imm, m_pc, m_cnt, ea, eb;
    logic [4:0]  m_rd;
    logic [7:0]  m_ctrl;

    for (int i = 0; i < 32; i++) regs[i] = 16'h0;
    regs[3] = 16'h1234; regs[5] = 16'h5555; regs[6] = 16'h6666;
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    check("reset out_valid", out_valid, 0);
    check("reset op_a", out_op_a, 0);
    check("reset op_b", out_op_b, 0);
    check("reset imm", out_imm, 0);
    check("reset pc", out_pc, 0);
    check("reset rd", out_rd, 0);
    check("reset ctrl", out_ctrl, 0);
    check("reset stall", stall_count, 0);
    exp_stall = 0;

    //          rs1 rs2 u2 exwe exld exrd exres     mwe mrd mres      wwe waddr wdata     exp_a     exp_b
    vecs[0] = '{3,  0,  1, 0,   0,   0,   16'h0,    0,  0,  16'h0,    0,  0,    16'h0,    16'h1234, 16'h0};
    vecs[1] = '{5,  6,  1, 1,   0,   5,   16'hAAAA, 1,  5,  16'hBBBB, 1,  5,    16'hCCCC, 16'hAAAA, 16'h6666};
    vecs[2] = '{5,  6,  1, 0,   0,   5,   16'hAAAA, 1,  5,  16'hBBBB, 1,  5,    16'hCCCC, 16'hBBBB, 16'h6666};
    vecs[3] = '{5,  6,  1, 0,   0,   5,   16'hAAAA, 0,  5,  16'hBBBB, 1,  5,    16'hCCCC, 16'hCCCC, 16'h6666};
    vecs[4] = '{0,  6,  1, 1,   0,   0,   16'hFFFF, 0,  0,  16'h0,    0,  0,    16'h0,    16'h0,    16'h6666};
    vecs[5] = '{5,  0,  1, 0,   0,   0,   16'h0,    0,  0,  16'h0,    0,  0,    16'h0,    16'hCCCC, 16'h0};
    vecs[6] = '{6,  3,  1, 1,   1,   9,   16'h1111, 1,  3,  16'h0BEE, 0,  0,    16'h0,    16'h6666, 16'h0BEE};
    vecs[7] = '{6,  3,  0, 1,   1,   3,   16'h2222, 0,  0,  16'h0,    0,  0,    16'h0,    16'h6666, 16'h1234};
    vecs[8] = '{6,  0,  1, 0,   0,   6,   16'h3333, 1,  6,  16'h7777, 0,  0,    16'h0,    16'h7777, 16'h0};

    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      in_valid = 1; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_use_rs2 = vecs[i].use2;
      ex_reg_write = vecs[i].ex_we; ex_is_load = vecs[i].ex_ld; ex_rd = vecs[i].ex_rd;
      ex_result = vecs[i].ex_res;
      mem_reg_write = vecs[i].mem_we; mem_rd = vecs[i].mem_rd; mem_result = vecs[i].mem_res;
      wb_write_enable = vecs[i].wb_we; wb_address = vecs[i].wb_addr; wb_data = vecs[i].wb_dat;
      in_rd = 5'(i + 1); in_imm = 16'(i * 16'h0101); in_ctrl = 8'(8'h10 + i); in_pc = 16'(16'h100 + i);
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      check($sformatf("vec%0d rf_addr1", i), rf_read_address1, vecs[i].rs1);
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d op_a", i), out_op_a, vecs[i].exp_a);
      check($sformatf("vec%0d op_b", i), out_op_b, vecs[i].exp_b);
      check($sformatf("vec%0d imm", i), out_imm, 16'(i * 16'h0101));
      check($sformatf("vec%0d rd/ctrl/pc", i), {out_rd, out_ctrl, out_pc}, {5'(i + 1), 8'(8'h10 + i), 16'(16'h100 + i)});
    end

    // Load-use: one bubble, then the loaded value arrives via MEM.
    clear_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 7; ex_reg_write = 1; ex_is_load = 1; ex_rd = 7;
    #1;
    check("loaduse in_ready", in_ready, 0);
    step(); exp_stall++;
    check("loaduse bubble", out_valid, 0);
    check("loaduse stall", stall_count, 16'(exp_stall));
    ex_reg_write = 0; ex_is_load = 0;
    mem_reg_write = 1; mem_rd = 7; mem_result = 16'h00FF; in_pc = 16'h0200;
    #1;
    check("loaduse retry ready", in_ready, 1);
    step();
    check("loaduse out_valid", out_valid, 1);
    check("loaduse op_b", out_op_b, 16'h00FF);

    // Backpressure: outputs frozen while EX stalls.
    clear_inputs();
    out_ready = 0; in_valid = 1; in_rs1 = 3; in_pc = 16'h0300;
    mem_reg_write = 1; mem_rd = 7; mem_result = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      step();
      check("bp held", {out_valid, out_op_b, out_pc}, {1'b1, 16'h00FF, 16'h0200});
    end
    out_ready = 1;
    #1;
    check("bp release ready", in_ready, 1);
    step();
    check("bp new op_a", out_op_a, 16'h1234);
    check("bp new pc", out_pc, 16'h0300);

    // Flush during a hazard: no count, slot emptied.
    clear_inputs();
    in_valid = 1; in_rs1 = 4; ex_reg_write = 1; ex_is_load = 1; ex_rd = 4; flush = 1;
    #1;
    check("flush in_ready", in_ready, 0);
    step();
    check("flush out_valid", out_valid, 0);
    check("flush stall", stall_count, 16'(exp_stall));
    flush = 0;
    step(); exp_stall++;
    check("hazard after flush", stall_count, 16'(exp_stall));

    // Saturation on the narrow counter, then reset mid-stall.
    for (int c = 0; c < 20; c++) step();
    exp_stall += 20;
    check("wide stall", stall_count, 16'(exp_stall));
    check("narrow saturate", stall_count4, 4'hF);
    reset = 1;
    step();
    reset = 0;
    check("reset mid-stall wide", stall_count, 0);
    check("reset mid-stall narrow", stall_count4, 0);
    check("reset mid-stall valid", out_valid, 0);

    // Random traffic against the model.
    clear_inputs();
    m_valid = 0; m_cnt = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_ctrl = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
      in_rd = 5'($urandom); in_imm = 16'($urandom); in_ctrl = 8'($urandom); in_pc = 16'($urandom);
      ex_reg_write = 1'($urandom); ex_is_load = 1'($urandom_range(0, 2) == 0);
      ex_rd = 5'($urandom_range(0, 7)); ex_result = 16'($urandom);
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = 16'($urandom);
      wb_write_enable = 1'($urandom); wb_address = 5'($urandom_range(0, 7)); wb_data = 16'($urandom);
      flush = 1'($urandom_range(0, 15) == 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      h = in_valid && ex_reg_write && ex_is_load && ex_rd != 0 &&
          ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
      rdy = !flush && !h && (!m_valid || out_ready);
      ea = resolve(in_rs1);
      eb = resolve(in_rs2);
      check("rand in_ready", in_ready, rdy);
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
        m_valid = 1; m_a = ea; m_b = eb; m_imm = in_imm; m_pc = in_pc; m_rd = in_rd; m_ctrl = in_ctrl;
      end else if (m_valid && out_ready) m_valid = 0;
      if (h && !flush && m_cnt != 16'hFFFF) m_cnt++;
      step();
      check("rand out_valid", out_valid, m_valid);
      check("rand stall", stall_count, m_cnt);
      if (m_valid) begin
        check("rand operands", {out_op_a, out_op_b}, {m_a, m_b});
        check("rand fields", {out_imm, out_pc, out_rd, out_ctrl}, {m_imm, m_pc, m_rd, m_ctrl});
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
